// File: rtl/det_event_logger.sv
// Timestamps rising edges of the 11011 detector output and queues them in a show-ahead FIFO.
// Also keeps a saturating event count and a sticky overflow flag.
module det_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     det_in,
    input  logic                     clr,
    output logic [TS_W-1:0]          ts_out,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [CNT_W-1:0]         event_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]       FullLvl = (AW+1)'(DEPTH);
    localparam logic [AW:0]       PtrOne  = (AW+1)'(1);
    localparam logic [TS_W-1:0]   TsOne   = TS_W'(1);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             det_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  ts_out_q, ts_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic evt, full, empty, pop, push;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign empty      = (fifo_level == '0);
    assign full       = (fifo_level == FullLvl);
    assign evt        = det_in & ~det_q;
    assign pop        = ~empty & ts_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = evt & (~full | pop);

    assign ts_valid   = ~empty;
    assign ts_out     = ts_out_q;
    assign event_cnt  = cnt_q;
    assign overflow   = ovf_q;

    always_comb begin
        ts_d     = ts_q + TsOne;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        ts_out_d = ts_out_q;
        if (clr) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (evt && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (evt && (cnt_q != '1)) begin
                cnt_d = cnt_q + CntOne;
            end
            // Head register tracks the next oldest entry; bypass when it is the one being written.
            if (wr_ptr_d != rd_ptr_d) begin
                ts_out_d = (rd_ptr_d == wr_ptr_q) ? ts_q : mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            det_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ts_out_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            det_q    <= det_in;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ts_out_q <= ts_out_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: doc/det_event_logger.md
Name: det_event_logger

Overview:
- Downstream consumer of the 11011 Moore sequence detector's output `y`.
- Timestamps every detection event and buffers the timestamps in a small show-ahead FIFO, read by a host over a valid/ready handshake.
- Also keeps a saturating total-event count and a sticky overflow flag.
- Lets a bench or CPU read back where in the bit stream each 11011 match occurred.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of each FIFO entry.
- DEPTH, 4, FIFO depth in entries; must be a power of two and >= 2.
- CNT_W, 8, width of the saturating total-event counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- det_in  input  1  detector output `y` (Moore, registered upstream).
- clr  input  1  synchronous clear of log state.
- ts_out  output  TS_W  timestamp at FIFO head; valid only when ts_valid=1.
- ts_valid  output  1  FIFO non-empty.
- ts_ready  input  1  consumer accepts head this cycle.
- event_cnt  output  CNT_W  total detected events, saturating.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- fifo_level  output  $clog2(DEPTH)+1  number of entries held, 0..DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous): timestamp=0, det_q=0, FIFO empty, fifo_level=0, ts_valid=0, ts_out=0, event_cnt=0, overflow=0.
  - Reset mid-operation discards all buffered entries immediately.
- Timestamp counter:
  - Increments by 1 every clock edge after reset, wrapping modulo 2^TS_W.
  - Not stalled by any input.
- Event definition: rising edge of det_in. At an edge where det_in=1 and det_q=0, event=1.
  - det_q <= det_in on every edge.
  - A det_in held high for N cycles is exactly one event.
- Captured value: the timestamp value present before the edge, i.e. the current-cycle value, not the incremented one.
- Push latency: an event sampled at edge k makes the entry visible, with ts_valid=1, from edge k onward, i.e. one cycle after det_in rises.
- Pop: ts_valid & ts_ready at an edge removes the head. ts_ready while empty has no effect.
- FIFO is show-ahead: ts_out always shows the oldest entry. When empty, ts_out holds its last value and ts_valid=0.
- Simultaneous push and pop:
  - Empty: push only.
  - Full: the pop frees a slot, the push is accepted and overflow stays unchanged.
  - Otherwise: both apply and fifo_level is unchanged.
- Full with no pop and an event: entry dropped, overflow <= 1 (sticky), event_cnt still increments.
- event_cnt: +1 per event regardless of FIFO state. Holds at 2^CNT_W-1 (no wrap).
- clr=1 (synchronous, highest priority over push/pop/count):
  - FIFO emptied, event_cnt=0, overflow=0, timestamp=0.
  - An event in the same cycle is ignored.
  - det_q still updates, so a det_in high held across clr does not re-trigger.
- Pointers: DEPTH is a power of two; read and write pointers wrap naturally. fifo_level is derived from the pointer difference, with one extra bit.
- No combinational path from ts_ready to ts_valid or ts_out. Outputs are registered or decoded from registered state only.

Test Plan:
- Reset then det_in pulses (1 cycle each) at timestamps 5, 9, 20, with ts_ready=0:
  - fifo_level=3, event_cnt=3, overflow=0.
  - Then ts_ready=1 pops 5, 9, 20 in order; ts_valid drops after the third pop.
- det_in held high for timestamps 10..14 -> exactly one entry (10), event_cnt=1.
- Six pulses with ts_ready=0 and DEPTH=4:
  - First four timestamps retained, overflow=1, event_cnt=6, fifo_level=4.
  - Drain returns only the first four; overflow stays 1 until clr.
- FIFO full, ts_ready=1 in the same cycle as an event -> head popped, new timestamp appended, fifo_level stays 4, overflow stays 0.
- Run so the timestamp wraps (TS_W=4 for the test): event at counter 15, next at 2 -> entries 15 then 2.
- Saturation: CNT_W=3 with 9 events -> event_cnt=7.
- clr asserted with 2 entries held and det_in rising in the same cycle -> next cycle fifo_level=0, event_cnt=0, overflow=0, timestamp=0, no new entry.
- rst_n pulsed low asynchronously mid-stream -> all outputs 0 before the next clock edge.
